// File: rtl/manch_pkg.sv
// Shared Manchester link definitions: frame state encoding, sync length,
// chip ordering for each data value, and the bit-to-chip helper.
// Used by manchester_tx and by the matching receiver.
package manch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } manch_state_e;

    localparam int unsigned SYNC_CHIPS = 2;

    // Level of the first chip of a bit; the second chip is its complement.
    localparam logic CHIP_ONE_FIRST  = 1'b1;
    localparam logic CHIP_ZERO_FIRST = 1'b0;

    // Line level for one half of a Manchester-encoded data bit.
    function automatic logic manch_chip(input logic data_bit, input logic second_half);
        logic first_lvl;
        first_lvl = data_bit ? CHIP_ONE_FIRST : CHIP_ZERO_FIRST;
        return second_half ? ~first_lvl : first_lvl;
    endfunction

endpackage

// File: rtl/manch_chip_timer.sv
// Chip-period divider for the Manchester transmitter.
// Counts CHIP_DIV clkin cycles per chip while running.
// Ports:
//   clkin      - system clock
//   rst        - synchronous active-high reset
//   clear      - next cycle is the first cycle of a new chip sequence
//   run        - next cycle lies inside a frame
//   chip_stb   - registered, high in the first cycle of every chip
//   chip_end_c - combinational, high in the last cycle of the current chip
module manch_chip_timer #(
    parameter int unsigned CHIP_DIV = 1
) (
    input  logic clkin,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic chip_stb,
    output logic chip_end_c
);

    localparam int unsigned CNT_W = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHIP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             chip_stb_q;
    logic             chip_stb_d;

    assign chip_end_c = (cnt_q == CNT_LAST);

    // Count within the chip; wrap at the chip end, park at zero when idle.
    always_comb begin
        cnt_d      = '0;
        chip_stb_d = 1'b0;
        if (run) begin
            if (clear || chip_end_c) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            chip_stb_d = (cnt_d == '0);
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            cnt_q      <= '0;
            chip_stb_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            chip_stb_q <= chip_stb_d;
        end
    end

    assign chip_stb = chip_stb_q;

endmodule

// File: rtl/manchester_tx.sv
// Manchester encoder / serial transmitter.
// Frame: idle level, two sync chips at ~IDLE_LEVEL, then DATA_W bits MSB-first,
// two chips per bit. With MANCH_TX_PARITY_EN defined, an even-parity bit of
// the latched word follows the data bits.
// Ports:
//   clkin     - system clock, all logic on posedge
//   rst       - synchronous active-high reset
//   din       - word to transmit, sampled only on the accept cycle
//   din_valid - din holds a word to send
//   din_ready - high only in IDLE
//   dout      - registered Manchester line
//   busy      - frame in progress
//   chip_stb  - pulse in the first cycle of every chip
//   done      - pulse in the cycle after the last chip
module manchester_tx
    import manch_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CHIP_DIV   = 1,
    parameter int unsigned IDLE_LEVEL = 0
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              busy,
    output logic              chip_stb,
    output logic              done
);

    localparam logic IDLE_BIT = 1'(IDLE_LEVEL);
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic SYNC_LAST = 1'(SYNC_CHIPS - 1);

    manch_state_e      state_q;
    manch_state_e      state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_d;
    logic              chip_cnt_q;
    logic              chip_cnt_d;
    logic              dout_q;
    logic              dout_d;
    logic              din_ready_q;
    logic              din_ready_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
`ifdef MANCH_TX_PARITY_EN
    logic              par_q;
    logic              par_d;
`endif

    logic              timer_clear_c;
    logic              timer_run_c;
    logic              chip_end_c;
    logic              frame_end_c;
    logic [DATA_W-1:0] shift_nxt_c;

    manch_chip_timer #(
        .CHIP_DIV (CHIP_DIV)
    ) u_timer (
        .clkin      (clkin),
        .rst        (rst),
        .clear      (timer_clear_c),
        .run        (timer_run_c),
        .chip_stb   (chip_stb),
        .chip_end_c (chip_end_c)
    );

    assign shift_nxt_c = shift_q << 1;

    // Next-state and next-output logic; dout_d is the level of the next cycle.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        chip_cnt_d    = chip_cnt_q;
        dout_d        = dout_q;
        din_ready_d   = din_ready_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        timer_clear_c = 1'b0;
        frame_end_c   = 1'b0;
`ifdef MANCH_TX_PARITY_EN
        par_d         = par_q;
`endif

        case (state_q)
            IDLE: begin
                dout_d      = IDLE_BIT;
                busy_d      = 1'b0;
                din_ready_d = 1'b1;
                if (din_valid && din_ready_q) begin
                    state_d       = SYNC;
                    shift_d       = din;
                    bit_cnt_d     = '0;
                    chip_cnt_d    = 1'b0;
                    dout_d        = ~IDLE_BIT;
                    busy_d        = 1'b1;
                    din_ready_d   = 1'b0;
                    timer_clear_c = 1'b1;
`ifdef MANCH_TX_PARITY_EN
                    par_d         = ^din;
`endif
                end
            end

            // Both sync chips repeat ~IDLE_BIT, a pattern no data bit can form.
            SYNC: begin
                if (chip_end_c) begin
                    if (chip_cnt_q == SYNC_LAST) begin
                        state_d    = DATA;
                        chip_cnt_d = 1'b0;
                        dout_d     = manch_chip(shift_q[DATA_W-1], 1'b0);
                    end else begin
                        chip_cnt_d = chip_cnt_q + 1'b1;
                        dout_d     = ~IDLE_BIT;
                    end
                end
            end

            // chip_cnt_q selects the half of the current bit; MSB is on air.
            DATA: begin
                if (chip_end_c) begin
                    if (!chip_cnt_q) begin
                        chip_cnt_d = 1'b1;
                        dout_d     = manch_chip(shift_q[DATA_W-1], 1'b1);
                    end else begin
                        chip_cnt_d = 1'b0;
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef MANCH_TX_PARITY_EN
                            state_d = PAR;
                            dout_d  = manch_chip(par_q, 1'b0);
`else
                            frame_end_c = 1'b1;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            shift_d   = shift_nxt_c;
                            dout_d    = manch_chip(shift_nxt_c[DATA_W-1], 1'b0);
                        end
                    end
                end
            end

`ifdef MANCH_TX_PARITY_EN
            PAR: begin
                if (chip_end_c) begin
                    if (!chip_cnt_q) begin
                        chip_cnt_d = 1'b1;
                        dout_d     = manch_chip(par_q, 1'b1);
                    end else begin
                        frame_end_c = 1'b1;
                    end
                end
            end
`endif

            default: begin
                frame_end_c = 1'b1;
            end
        endcase

        // Return to idle after the final chip; done marks the completion.
        if (frame_end_c) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            chip_cnt_d  = 1'b0;
            dout_d      = IDLE_BIT;
            busy_d      = 1'b0;
            din_ready_d = 1'b1;
            done_d      = (state_q != IDLE);
        end

        timer_run_c = busy_d;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            chip_cnt_q  <= 1'b0;
            dout_q      <= IDLE_BIT;
            din_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MANCH_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            chip_cnt_q  <= chip_cnt_d;
            dout_q      <= dout_d;
            din_ready_q <= din_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef MANCH_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign din_ready = din_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_manchester_tx.sv
// Bench for manchester_tx: two instances (CHIP_DIV=1 and CHIP_DIV=3) share
// din/rst; sel picks which one receives din_valid and is observed.
module tb_manchester_tx;

    localparam int unsigned DATA_W   = 8;
    localparam logic        IDLE_LVL = 1'b0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              sel = 1'b0;

    logic valid1, ready1, dout1, busy1, stb1, done1;
    logic valid3, ready3, dout3, busy3, stb3, done3;
    logic o_ready, o_dout, o_busy, o_stb, o_done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign valid1  = din_valid & ~sel;
    assign valid3  = din_valid & sel;
    assign o_ready = sel ? ready3 : ready1;
    assign o_dout  = sel ? dout3  : dout1;
    assign o_busy  = sel ? busy3  : busy1;
    assign o_stb   = sel ? stb3   : stb1;
    assign o_done  = sel ? done3  : done1;

    manchester_tx #(.DATA_W(DATA_W), .CHIP_DIV(1), .IDLE_LEVEL(0)) u_dut1 (
        .clkin     (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (valid1),
        .din_ready (ready1),
        .dout      (dout1),
        .busy      (busy1),
        .chip_stb  (stb1),
        .done      (done1)
    );

    manchester_tx #(.DATA_W(DATA_W), .CHIP_DIV(3), .IDLE_LEVEL(0)) u_dut3 (
        .clkin     (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (valid3),
        .din_ready (ready3),
        .dout      (dout3),
        .busy      (busy3),
        .chip_stb  (stb3),
        .done      (done3)
    );

    typedef logic chip_q_t[$];

    // Reference frame as a chip list: sync pair, then each bit as (b, ~b).
    function automatic chip_q_t frame_chips(input logic [DATA_W-1:0] w);
        chip_q_t q;
        q = {};
        repeat (2) q.push_back(~IDLE_LVL);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            q.push_back(w[i]);
            q.push_back(~w[i]);
        end
`ifdef MANCH_TX_PARITY_EN
        q.push_back(^w);
        q.push_back(~(^w));
`endif
        return q;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b (sel=%0d t=%0t)", tag, obs, exp, sel, $time);
    endtask

    // Present w at the current negedge; it is accepted at the next posedge.
    task automatic accept(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] after_din,
                          input logic after_valid);
        din       = w;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din       = after_din;
        din_valid = after_valid;
    endtask

    // Check every cycle of the frame after accept, then the done cycle.
    task automatic check_frame(input logic [DATA_W-1:0] w, input int unsigned div);
        chip_q_t chips;
        chips = frame_chips(w);
        foreach (chips[k]) begin
            for (int j = 0; j < int'(div); j++) begin
                @(negedge clk);
                chk("frame_dout", o_dout, chips[k]);
                chk("frame_chip_stb", o_stb, (j == 0));
                chk("frame_busy", o_busy, 1'b1);
                chk("frame_din_ready", o_ready, 1'b0);
                chk("frame_done", o_done, 1'b0);
            end
        end
        @(negedge clk);
        chk("end_done", o_done, 1'b1);
        chk("end_dout", o_dout, IDLE_LVL);
        chk("end_din_ready", o_ready, 1'b1);
        chk("end_busy", o_busy, 1'b0);
        chk("end_chip_stb", o_stb, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned       div;
        int                gap;
        logic [DATA_W-1:0] w;
        chip_q_t           c;

        // Reset values, with din_valid asserted during reset (reset wins).
        rst = 1'b1;
        repeat (2) @(negedge clk);
        din       = 8'hFF;
        din_valid = 1'b1;
        @(negedge clk);
        chk("rst_dout1", dout1, IDLE_LVL);
        chk("rst_ready1", ready1, 1'b1);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_stb1", stb1, 1'b0);
        chk("rst_done1", done1, 1'b0);
        chk("rst_dout3", dout3, IDLE_LVL);
        chk("rst_ready3", ready3, 1'b1);
        chk("rst_busy3", busy3, 1'b0);
        chk("rst_stb3", stb3, 1'b0);
        chk("rst_done3", done3, 1'b0);
        din_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        chk("post_rst_busy1", busy1, 1'b0);
        chk("post_rst_dout1", dout1, IDLE_LVL);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            div = (s == 0) ? 1 : 3;
            @(negedge clk);
            chk("idle_ready", o_ready, 1'b1);

            // Directed words.
            accept(8'hA5, 8'h00, 1'b0);
            check_frame(8'hA5, div);
            @(negedge clk);
            accept(8'h00, 8'hFF, 1'b0);
            check_frame(8'h00, div);

            // din_valid held high, din changes mid-frame; second word taken on done cycle.
            @(negedge clk);
            accept(8'h11, 8'h22, 1'b1);
            check_frame(8'h11, div);
            accept(8'h22, 8'h5A, 1'b0);
            check_frame(8'h22, div);

            // Reset in the 7th data chip, together with din_valid.
            @(negedge clk);
            accept(8'hC3, 8'h00, 1'b0);
            c = frame_chips(8'hC3);
            repeat (8 * div + 1) @(negedge clk);
            chk("pre_rst_dout", o_dout, c[8]);
            chk("pre_rst_stb", o_stb, 1'b1);
            rst       = 1'b1;
            din       = 8'hFF;
            din_valid = 1'b1;
            @(negedge clk);
            chk("midrst_dout", o_dout, IDLE_LVL);
            chk("midrst_busy", o_busy, 1'b0);
            chk("midrst_ready", o_ready, 1'b1);
            chk("midrst_done", o_done, 1'b0);
            chk("midrst_stb", o_stb, 1'b0);
            rst       = 1'b0;
            din_valid = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("after_rst_done", o_done, 1'b0);
                chk("after_rst_busy", o_busy, 1'b0);
                chk("after_rst_dout", o_dout, IDLE_LVL);
            end

            // Random words with random idle gaps (gap 0 = back-to-back).
            repeat (12) begin
                w   = DATA_W'($urandom);
                gap = int'($urandom_range(0, 2));
                repeat (gap) begin
                    @(negedge clk);
                    chk("gap_dout", o_dout, IDLE_LVL);
                    chk("gap_busy", o_busy, 1'b0);
                end
                accept(w, DATA_W'($urandom), 1'b0);
                check_frame(w, div);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
